ddr_cmd_tracker: RTL and testbench
==================================

Name: ddr_cmd_tracker

Overview:
- Registered DDR4 command decoder with multi-rank chip-select and bank-group/bank addressing.
- Keeps a per-bank open/closed state and open-row table, and flags protocol-illegal commands.
- Keeps saturating activity counters.
- Sits between the host-side DDR pin interface and the bank FSMs / timing checkers of the DRAM emulation.

Parameters:
- ADDRWIDTH, 17: width of A; A[ADDRWIDTH-1]=RAS_n, A[ADDRWIDTH-2]=CAS_n, A[ADDRWIDTH-3]=WE_n, A[10]=AP.
- COLWIDTH, 10: column bits, taken from A[COLWIDTH-1:0].
- BGWIDTH, 2: bank-group address bits.
- BAWIDTH, 2: bank address bits per group.
- RANKS, 1: number of ranks, one cs_n bit each.
- CNTWIDTH, 32: width of the activity counters.
- Derived: BANKS = 2**(BGWIDTH+BAWIDTH); RKW = max(1,$clog2(RANKS)).

Ports:
- clk  in  1  command clock
- reset_n  in  1  asynchronous, active-low reset
- cke  in  1  clock enable
- cs_n  in  RANKS  chip selects, active low
- act_n  in  1  activate command input
- A  in  ADDRWIDTH  row address / command pins
- bg  in  BGWIDTH  bank group
- ba  in  BAWIDTH  bank
- cmd_valid  out  1  decoded command present this cycle
- cmd  out  4  cmd_e code (package)
- cmd_rank  out  RKW  target rank
- cmd_bank  out  BGWIDTH+BAWIDTH  {bg,ba}
- cmd_row  out  ADDRWIDTH  ACT: A; RD/WR: stored open row of target bank; else 0
- cmd_col  out  COLWIDTH  column for RD/WR, else 0
- bank_open  out  RANKS*BANKS  open flag per bank, index rank*BANKS+bank
- illegal  out  1  protocol violation pulse
- illegal_code  out  3  ill_e code (package)
- act_cnt, rd_cnt, wr_cnt  out  CNTWIDTH each  saturating counts of legal ACT, RD/RDA, WR/WRA

Behaviour:
- Reset (reset_n low, async): all outputs 0, all banks closed, row table 0, counters 0, cmd = NOP.
- Latency: pins sampled on rising clk; all outputs are registered and valid the next cycle; bank_open shows post-command state in the same cycle as cmd_valid.
- Select:
  - No cs_n low -> cmd_valid=0, cmd=DES.
  - More than one cs_n low -> illegal=1, code MULTI_CS, cmd_valid=0, no state change.
- Decode with exactly one cs_n low: act_n=0 -> ACT. With act_n=1, {RAS,CAS,WE}:
  - LLL -> MRS
  - LLH -> REF if cke=1, SRE if cke=0
  - LHL -> PRE (AP=0) / PREA (AP=1)
  - LHH -> RFU: illegal, code RFU
  - HLL -> WR / WRA
  - HLH -> RD / RDA
  - HHL -> ZQC
  - HHH -> NOP with cmd_valid=1
- Bank rules (target = cmd_rank, {bg,ba}):
  - ACT to a closed bank: open it, store row = A.
  - ACT to an open bank: illegal ACT_OPEN; state and row unchanged.
  - RD/WR/RDA/WRA to a closed bank: illegal RW_CLOSED; no count.
  - RDA/WRA: close the bank after the access; cmd_row reports the pre-close row.
  - PRE: close the target bank. PRE to a closed bank is legal (NOP).
  - PREA: close all banks of the rank.
  - REF, SRE or MRS with any bank of the rank open: illegal BANK_OPEN; no state change.
- On an illegal command: cmd_valid=1, cmd is still reported, illegal pulses for one cycle, and no bank or counter update occurs.
- Counters saturate at all-ones with no wrap; they increment only on legal commands.
- cke low with cs_n high: treated as DES; power-down is not modelled.

Decomposition:
- ddr_cmd_pkg: cmd_e {DES,NOP,ACT,RD,RDA,WR,WRA,PRE,PREA,REF,SRE,MRS,ZQC,RFU}; ill_e {NONE,MULTI_CS,RFU,ACT_OPEN,RW_CLOSED,BANK_OPEN}; pin-position localparams (RAS/CAS/WE/AP offsets).
- Sub-module bank_state_table, one instance per rank:
  - Holds BANKS open bits plus row registers.
  - Ports: open/close/close_all strobes, bank index, row in, row out, open vector.
- Top level holds the decode, rank select, illegality logic and counters.

Test Plan:
- Reset mid-stream: ACT rank0 bank5 row 0x1ABC, then assert reset_n=0 asynchronously -> bank_open=0 immediately, counters 0, cmd=NOP.
- ACT bg=1 ba=1 row 0x0123, then RD col 0x3F -> cmd=RD, cmd_row=0x0123, cmd_col=0x3F, rd_cnt=1, bank_open[5]=1.
- RDA to an open bank, then a further RD to the same bank -> first command closes bank_open[5]; second gives illegal=1 with code RW_CLOSED and rd_cnt unchanged.
- ACT to an already-open bank with a new row -> illegal ACT_OPEN; stored row still 0x0123.
- RANKS=2: cs_n=2'b00 -> MULTI_CS. ACT rank1 bank0, then PREA on rank0 -> rank1 bank stays open. REF on rank1 -> BANK_OPEN illegal. PREA on rank1, then REF -> legal REF.
- CNTWIDTH=4: 16 legal ACT/PRE pairs -> act_cnt saturates at 0xF.

Source files
------------

// File: rtl/ddr_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_cmd_pkg
// Description : Shared types for the DDR4 command tracker. It holds the decoded
//               command codes, the illegal-command codes and the positions of
//               the command pins inside the A bus.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_cmd_pkg;

  typedef enum logic [3:0] {
    CMD_DES  = 4'd0,
    CMD_NOP  = 4'd1,
    CMD_ACT  = 4'd2,
    CMD_RD   = 4'd3,
    CMD_RDA  = 4'd4,
    CMD_WR   = 4'd5,
    CMD_WRA  = 4'd6,
    CMD_PRE  = 4'd7,
    CMD_PREA = 4'd8,
    CMD_REF  = 4'd9,
    CMD_SRE  = 4'd10,
    CMD_MRS  = 4'd11,
    CMD_ZQC  = 4'd12,
    CMD_RFU  = 4'd13
  } cmd_e;

  typedef enum logic [2:0] {
    ILL_NONE      = 3'd0,
    ILL_MULTI_CS  = 3'd1,
    ILL_RFU       = 3'd2,
    ILL_ACT_OPEN  = 3'd3,
    ILL_RW_CLOSED = 3'd4,
    ILL_BANK_OPEN = 3'd5
  } ill_e;

  // The command pins sit at the top of A. These offsets count down from
  // ADDRWIDTH, so RAS_n is A[ADDRWIDTH-RAS_OFS].
  localparam int RAS_OFS = 1;
  localparam int CAS_OFS = 2;
  localparam int WE_OFS  = 3;
  // The auto-precharge / precharge-all bit has a fixed position.
  localparam int AP_BIT  = 10;

  // Column accesses: these need an open bank and report a column.
  function automatic logic is_rw(input cmd_e c);
    return (c == CMD_RD) || (c == CMD_RDA) || (c == CMD_WR) || (c == CMD_WRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_state_table.sv
`default_nettype none
// ============================================================================
// Module      : bank_state_table
// Description : Open/closed state and open-row storage for the banks of one
//               rank. The strobes are mutually exclusive, and the parent
//               asserts them only for legal commands.
// Ports       : clk, reset_n     - clock, asynchronous active-low reset
//               i_open           - open i_bank and store i_row as its row
//               i_close          - close i_bank
//               i_close_all      - close every bank of the rank
//               i_bank / i_row   - target bank index / row to store
//               o_row            - stored row of i_bank (combinational read)
//               o_open           - open flag per bank
// Revision    : 1.0 - initial release
// ============================================================================
module bank_state_table #(
  parameter int BANKS = 16,
  parameter int BKW   = 4,
  parameter int ROWW  = 17
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_open,
  input  logic            i_close,
  input  logic            i_close_all,
  input  logic [BKW-1:0]  i_bank,
  input  logic [ROWW-1:0] i_row,
  output logic [ROWW-1:0] o_row,
  output logic [BANKS-1:0] o_open
);

  logic [BANKS-1:0] r_open;
  logic [ROWW-1:0]  r_row [BANKS];

  // When a bank closes, its row register keeps the old value. Only the open
  // flag decides whether that row is meaningful.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open <= '0;
      for (int b = 0; b < BANKS; b++) begin
        r_row[b] <= '0;
      end
    end else begin
      if (i_close_all) begin
        r_open <= '0;
      end else if (i_open) begin
        r_open[i_bank] <= 1'b1;
        r_row[i_bank]  <= i_row;
      end else if (i_close) begin
        r_open[i_bank] <= 1'b0;
      end
    end
  end

  assign o_row  = r_row[i_bank];
  assign o_open = r_open;

endmodule
`default_nettype wire

// File: rtl/ddr_cmd_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ddr_cmd_tracker
// Description : Registered DDR4 command decoder. It decodes the command pins,
//               selects the rank from cs_n, tracks per-bank open state and
//               open rows, flags protocol-illegal commands and keeps
//               saturating ACT/RD/WR counters.
// Ports       : clk, reset_n           - clock, asynchronous active-low reset
//               cke, cs_n, act_n, A,
//               bg, ba                 - DDR4 command/address pins
//               cmd_valid, cmd         - decoded command (registered)
//               cmd_rank, cmd_bank     - command target
//               cmd_row, cmd_col       - row (ACT: A, RD/WR: open row) / column
//               bank_open              - open flag, index rank*BANKS+bank
//               illegal, illegal_code  - one-cycle violation pulse and reason
//               act_cnt, rd_cnt, wr_cnt- saturating legal-command counters
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_cmd_tracker
  import ddr_cmd_pkg::*;
#(
  parameter  int ADDRWIDTH = 17,
  parameter  int COLWIDTH  = 10,
  parameter  int BGWIDTH   = 2,
  parameter  int BAWIDTH   = 2,
  parameter  int RANKS     = 1,
  parameter  int CNTWIDTH  = 32,
  localparam int BKW       = BGWIDTH + BAWIDTH,
  localparam int BANKS     = 2 ** BKW,
  localparam int RKW       = (RANKS > 1) ? $clog2(RANKS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cke,
  input  logic [RANKS-1:0]       cs_n,
  input  logic                   act_n,
  input  logic [ADDRWIDTH-1:0]   A,
  input  logic [BGWIDTH-1:0]     bg,
  input  logic [BAWIDTH-1:0]     ba,
  output logic                   cmd_valid,
  output logic [3:0]             cmd,
  output logic [RKW-1:0]         cmd_rank,
  output logic [BKW-1:0]         cmd_bank,
  output logic [ADDRWIDTH-1:0]   cmd_row,
  output logic [COLWIDTH-1:0]    cmd_col,
  output logic [RANKS*BANKS-1:0] bank_open,
  output logic                   illegal,
  output logic [2:0]             illegal_code,
  output logic [CNTWIDTH-1:0]    act_cnt,
  output logic [CNTWIDTH-1:0]    rd_cnt,
  output logic [CNTWIDTH-1:0]    wr_cnt
);

  // --------------------------------------------------------------------------
  // Rank select
  // --------------------------------------------------------------------------
  logic [RANKS-1:0] w_cs_low;
  logic             w_multi;
  logic             w_one;
  logic [RKW-1:0]   w_rank;
  logic [BKW-1:0]   w_bank;

  assign w_cs_low = ~cs_n;
  // Clearing the lowest set bit leaves a nonzero value only if two or more
  // chip selects are low.
  assign w_multi  = (w_cs_low & (w_cs_low - RANKS'(1))) != '0;
  assign w_one    = (w_cs_low != '0) && !w_multi;
  assign w_bank   = {bg, ba};

  always_comb begin
    w_rank = '0;
    for (int r = 0; r < RANKS; r++) begin
      if (w_cs_low[r]) begin
        w_rank = RKW'(r);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  cmd_e w_cmd;
  logic w_ap;

  assign w_ap = A[AP_BIT];

  always_comb begin
    w_cmd = CMD_NOP;
    if (!act_n) begin
      w_cmd = CMD_ACT;
    end else begin
      case ({A[ADDRWIDTH-RAS_OFS], A[ADDRWIDTH-CAS_OFS], A[ADDRWIDTH-WE_OFS]})
        3'b000:  w_cmd = CMD_MRS;
        3'b001:  w_cmd = cke  ? CMD_REF  : CMD_SRE;
        3'b010:  w_cmd = w_ap ? CMD_PREA : CMD_PRE;
        3'b011:  w_cmd = CMD_RFU;
        3'b100:  w_cmd = w_ap ? CMD_WRA  : CMD_WR;
        3'b101:  w_cmd = w_ap ? CMD_RDA  : CMD_RD;
        3'b110:  w_cmd = CMD_ZQC;
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-rank bank tables
  // --------------------------------------------------------------------------
  logic [BANKS-1:0]     w_open_rank [RANKS];
  logic [ADDRWIDTH-1:0] w_row_rank  [RANKS];
  logic                 w_tgt_open;
  logic                 w_rank_open;
  logic [ADDRWIDTH-1:0] w_tgt_row;
  ill_e                 w_ill_code;
  logic                 w_legal;

  assign w_tgt_open  = w_open_rank[w_rank][w_bank];
  assign w_rank_open = |w_open_rank[w_rank];
  assign w_tgt_row   = w_row_rank[w_rank];

  generate
    for (genvar r = 0; r < RANKS; r++) begin : g_rank
      logic w_sel;
      assign w_sel = w_legal && (w_rank == RKW'(r));

      bank_state_table #(
        .BANKS (BANKS),
        .BKW   (BKW),
        .ROWW  (ADDRWIDTH)
      ) u_bank_state_table (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_open      (w_sel && (w_cmd == CMD_ACT)),
        .i_close     (w_sel && ((w_cmd == CMD_PRE) || (w_cmd == CMD_RDA) ||
                                (w_cmd == CMD_WRA))),
        .i_close_all (w_sel && (w_cmd == CMD_PREA)),
        .i_bank      (w_bank),
        .i_row       (A),
        .o_row       (w_row_rank[r]),
        .o_open      (w_open_rank[r])
      );

      assign bank_open[r*BANKS +: BANKS] = w_open_rank[r];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Illegality check
  // --------------------------------------------------------------------------
  always_comb begin
    w_ill_code = ILL_NONE;
    if (w_multi) begin
      w_ill_code = ILL_MULTI_CS;
    end else if (w_one) begin
      if (w_cmd == CMD_RFU) begin
        w_ill_code = ILL_RFU;
      end else if ((w_cmd == CMD_ACT) && w_tgt_open) begin
        w_ill_code = ILL_ACT_OPEN;
      end else if (is_rw(w_cmd) && !w_tgt_open) begin
        w_ill_code = ILL_RW_CLOSED;
      end else if (((w_cmd == CMD_REF) || (w_cmd == CMD_SRE) ||
                    (w_cmd == CMD_MRS)) && w_rank_open) begin
        w_ill_code = ILL_BANK_OPEN;
      end
    end
  end

  assign w_legal = w_one && (w_ill_code == ILL_NONE);

  // --------------------------------------------------------------------------
  // Registered command outputs
  // --------------------------------------------------------------------------
  logic                 r_cmd_valid;
  cmd_e                 r_cmd;
  logic [RKW-1:0]       r_cmd_rank;
  logic [BKW-1:0]       r_cmd_bank;
  logic [ADDRWIDTH-1:0] r_cmd_row;
  logic [COLWIDTH-1:0]  r_cmd_col;
  logic                 r_illegal;
  ill_e                 r_ill_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_cmd_rank  <= '0;
      r_cmd_bank  <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_illegal   <= 1'b0;
      r_ill_code  <= ILL_NONE;
    end else begin
      r_cmd_valid <= w_one;
      r_illegal   <= (w_ill_code != ILL_NONE);
      r_ill_code  <= w_ill_code;
      if (w_one) begin
        r_cmd      <= w_cmd;
        r_cmd_rank <= w_rank;
        r_cmd_bank <= w_bank;
        // The row is read before the edge, so RDA/WRA report the row that
        // was open before they close the bank.
        if (w_cmd == CMD_ACT) begin
          r_cmd_row <= A;
        end else if (is_rw(w_cmd)) begin
          r_cmd_row <= w_tgt_row;
        end else begin
          r_cmd_row <= '0;
        end
        r_cmd_col  <= is_rw(w_cmd) ? A[COLWIDTH-1:0] : '0;
      end else begin
        r_cmd      <= CMD_DES;
        r_cmd_rank <= '0;
        r_cmd_bank <= '0;
        r_cmd_row  <= '0;
        r_cmd_col  <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating activity counters (legal commands only)
  // --------------------------------------------------------------------------
  logic [CNTWIDTH-1:0] r_act_cnt;
  logic [CNTWIDTH-1:0] r_rd_cnt;
  logic [CNTWIDTH-1:0] r_wr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_cnt <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else if (w_legal) begin
      if ((w_cmd == CMD_ACT) && (r_act_cnt != '1)) begin
        r_act_cnt <= r_act_cnt + CNTWIDTH'(1);
      end
      if (((w_cmd == CMD_RD) || (w_cmd == CMD_RDA)) && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + CNTWIDTH'(1);
      end
      if (((w_cmd == CMD_WR) || (w_cmd == CMD_WRA)) && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + CNTWIDTH'(1);
      end
    end
  end

  assign cmd_valid    = r_cmd_valid;
  assign cmd          = r_cmd;
  assign cmd_rank     = r_cmd_rank;
  assign cmd_bank     = r_cmd_bank;
  assign cmd_row      = r_cmd_row;
  assign cmd_col      = r_cmd_col;
  assign illegal      = r_illegal;
  assign illegal_code = r_ill_code;
  assign act_cnt      = r_act_cnt;
  assign rd_cnt       = r_rd_cnt;
  assign wr_cnt       = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ddr_cmd_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_cmd_tracker
// Description : Directed, table-driven bench for ddr_cmd_tracker. One instance
//               uses the default single-rank configuration. A second instance
//               uses two ranks and 4-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_cmd_tracker;

  // Command codes
  localparam logic [3:0] C_DES = 4'd0,  C_NOP = 4'd1,  C_ACT = 4'd2,  C_RD  = 4'd3;
  localparam logic [3:0] C_RDA = 4'd4,  C_WR  = 4'd5,  C_WRA = 4'd6,  C_PRE = 4'd7;
  localparam logic [3:0] C_PREA= 4'd8,  C_REF = 4'd9,  C_SRE = 4'd10, C_MRS = 4'd11;
  localparam logic [3:0] C_ZQC = 4'd12, C_RFU = 4'd13;
  // Illegal codes
  localparam logic [2:0] I_NONE = 3'd0, I_MCS = 3'd1, I_RFU = 3'd2;
  localparam logic [2:0] I_AOPEN = 3'd3, I_RWCL = 3'd4, I_BOPEN = 3'd5;
  // {RAS_n,CAS_n,WE_n}
  localparam logic [2:0] P_MRS = 3'b000, P_REF = 3'b001, P_PRE = 3'b010, P_RFU = 3'b011;
  localparam logic [2:0] P_WR  = 3'b100, P_RD  = 3'b101, P_ZQC = 3'b110, P_NOP = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- DUT 1: defaults ----------------
  logic        d1_cke, d1_cs_n, d1_act_n;
  logic [16:0] d1_a;
  logic [1:0]  d1_bg, d1_ba;
  logic        d1_valid, d1_ill;
  logic [3:0]  d1_cmd, d1_bank;
  logic [0:0]  d1_rank;
  logic [16:0] d1_row;
  logic [9:0]  d1_col;
  logic [15:0] d1_open;
  logic [2:0]  d1_code;
  logic [31:0] d1_act, d1_rd, d1_wr;

  ddr_cmd_tracker u_dut1 (
    .clk(clk), .reset_n(reset_n), .cke(d1_cke), .cs_n(d1_cs_n), .act_n(d1_act_n),
    .A(d1_a), .bg(d1_bg), .ba(d1_ba), .cmd_valid(d1_valid), .cmd(d1_cmd),
    .cmd_rank(d1_rank), .cmd_bank(d1_bank), .cmd_row(d1_row), .cmd_col(d1_col),
    .bank_open(d1_open), .illegal(d1_ill), .illegal_code(d1_code),
    .act_cnt(d1_act), .rd_cnt(d1_rd), .wr_cnt(d1_wr)
  );

  // ---------------- DUT 2: two ranks, 4-bit counters ----------------
  logic        d2_cke, d2_act_n;
  logic [1:0]  d2_cs_n;
  logic [16:0] d2_a;
  logic [1:0]  d2_bg, d2_ba;
  logic        d2_valid, d2_ill;
  logic [3:0]  d2_cmd, d2_bank;
  logic [0:0]  d2_rank;
  logic [16:0] d2_row;
  logic [9:0]  d2_col;
  logic [31:0] d2_open;
  logic [2:0]  d2_code;
  logic [3:0]  d2_act, d2_rd, d2_wr;

  ddr_cmd_tracker #(.RANKS(2), .CNTWIDTH(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .cke(d2_cke), .cs_n(d2_cs_n), .act_n(d2_act_n),
    .A(d2_a), .bg(d2_bg), .ba(d2_ba), .cmd_valid(d2_valid), .cmd(d2_cmd),
    .cmd_rank(d2_rank), .cmd_bank(d2_bank), .cmd_row(d2_row), .cmd_col(d2_col),
    .bank_open(d2_open), .illegal(d2_ill), .illegal_code(d2_code),
    .act_cnt(d2_act), .rd_cnt(d2_rd), .wr_cnt(d2_wr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] mk(input logic [2:0] rcw, input logic ap, input logic [9:0] col);
    return {rcw, 3'b000, ap, col};
  endfunction

  typedef struct {
    logic        cs_n, act_n, cke;
    logic [16:0] a;
    logic [1:0]  bg, ba;
    logic        e_valid;
    logic [3:0]  e_cmd;
    logic [16:0] e_row;
    logic        row_dc;
    logic [9:0]  e_col;
    logic [15:0] e_open;
    logic [2:0]  e_code;
    logic [31:0] e_act, e_rd, e_wr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic cs, input logic an, input logic ck, input logic [16:0] a,
                     input logic [1:0] bg, input logic [1:0] ba, input logic v,
                     input logic [3:0] c, input logic [16:0] row, input logic dc,
                     input logic [9:0] col, input logic [15:0] op, input logic [2:0] code,
                     input logic [31:0] ac, input logic [31:0] rc, input logic [31:0] wc);
    vec_t t;
    t.cs_n = cs; t.act_n = an; t.cke = ck; t.a = a; t.bg = bg; t.ba = ba;
    t.e_valid = v; t.e_cmd = c; t.e_row = row; t.row_dc = dc; t.e_col = col;
    t.e_open = op; t.e_code = code; t.e_act = ac; t.e_rd = rc; t.e_wr = wc;
    vq.push_back(t);
  endtask

  task automatic drive2(input logic [1:0] cs, input logic an, input logic [16:0] a,
                        input logic [1:0] bg, input logic [1:0] ba);
    d2_cs_n = cs; d2_act_n = an; d2_cke = 1'b1; d2_a = a; d2_bg = bg; d2_ba = ba;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    d1_cs_n  = 1'b1; d1_act_n = 1'b1; d1_cke = 1'b1; d1_a = '0; d1_bg = '0; d1_ba = '0;
    d2_cs_n  = 2'b11; d2_act_n = 1'b1; d2_cke = 1'b1; d2_a = '0; d2_bg = '0; d2_ba = '0;
    repeat (3) @(posedge clk);
    #2;
    // Reset state
    check("rst.valid", d1_valid, 0);
    check("rst.cmd",   d1_cmd,   C_NOP);
    check("rst.open",  d1_open,  0);
    check("rst.ill",   d1_ill,   0);
    check("rst.act",   d1_act,   0);
    check("rst.d2open", d2_open, 0);
    reset_n = 1'b1;

    //   cs an ck A                    bg ba  v  cmd     row       dc col     open     code     act rd wr
    add(1, 1, 1, mk(P_NOP,0,0),        0, 0,  0, C_DES,  0,        0, 0,      16'h0000, I_NONE,  0, 0, 0);
    add(0, 0, 1, 17'h00123,            1, 1,  1, C_ACT,  17'h0123, 0, 0,      16'h0020, I_NONE,  1, 0, 0);
    add(0, 1, 1, mk(P_RD,0,10'h3F),    1, 1,  1, C_RD,   17'h0123, 0, 10'h3F, 16'h0020, I_NONE,  1, 1, 0);
    add(0, 0, 1, 17'h00456,            1, 1,  1, C_ACT,  17'h0456, 0, 0,      16'h0020, I_AOPEN, 1, 1, 0);
    add(0, 1, 1, mk(P_RD,0,10'h10),    1, 1,  1, C_RD,   17'h0123, 0, 10'h10, 16'h0020, I_NONE,  1, 2, 0);
    add(0, 1, 1, mk(P_WR,0,10'h5),     0, 0,  1, C_WR,   0,        1, 10'h5,  16'h0020, I_RWCL,  1, 2, 0);
    add(0, 1, 1, mk(P_REF,0,0),        0, 0,  1, C_REF,  0,        0, 0,      16'h0020, I_BOPEN, 1, 2, 0);
    add(0, 1, 0, mk(P_REF,0,0),        0, 0,  1, C_SRE,  0,        0, 0,      16'h0020, I_BOPEN, 1, 2, 0);
    add(0, 1, 1, mk(P_MRS,0,0),        0, 0,  1, C_MRS,  0,        0, 0,      16'h0020, I_BOPEN, 1, 2, 0);
    add(0, 1, 1, mk(P_RFU,0,0),        0, 0,  1, C_RFU,  0,        0, 0,      16'h0020, I_RFU,   1, 2, 0);
    add(0, 1, 1, mk(P_ZQC,0,0),        0, 0,  1, C_ZQC,  0,        0, 0,      16'h0020, I_NONE,  1, 2, 0);
    add(0, 1, 1, mk(P_NOP,0,0),        0, 0,  1, C_NOP,  0,        0, 0,      16'h0020, I_NONE,  1, 2, 0);
    add(0, 1, 1, mk(P_RD,1,10'h7),     1, 1,  1, C_RDA,  17'h0123, 0, 10'h7,  16'h0000, I_NONE,  1, 3, 0);
    add(0, 1, 1, mk(P_RD,0,10'h3F),    1, 1,  1, C_RD,   0,        1, 10'h3F, 16'h0000, I_RWCL,  1, 3, 0);
    add(0, 1, 1, mk(P_REF,0,0),        0, 0,  1, C_REF,  0,        0, 0,      16'h0000, I_NONE,  1, 3, 0);
    add(0, 0, 1, 17'h01ABC,            2, 3,  1, C_ACT,  17'h1ABC, 0, 0,      16'h0800, I_NONE,  2, 3, 0);
    add(0, 1, 1, mk(P_WR,0,10'h155),   2, 3,  1, C_WR,   17'h1ABC, 0, 10'h155,16'h0800, I_NONE,  2, 3, 1);
    add(0, 1, 1, mk(P_WR,1,10'h2),     2, 3,  1, C_WRA,  17'h1ABC, 0, 10'h2,  16'h0000, I_NONE,  2, 3, 2);
    add(0, 0, 1, 17'h1FFFF,            0, 0,  1, C_ACT,  17'h1FFFF,0, 0,      16'h0001, I_NONE,  3, 3, 2);
    add(0, 0, 1, 17'h00042,            0, 3,  1, C_ACT,  17'h0042, 0, 0,      16'h0009, I_NONE,  4, 3, 2);
    add(0, 1, 1, mk(P_PRE,0,0),        0, 0,  1, C_PRE,  0,        0, 0,      16'h0008, I_NONE,  4, 3, 2);
    add(0, 1, 1, mk(P_PRE,0,0),        0, 0,  1, C_PRE,  0,        0, 0,      16'h0008, I_NONE,  4, 3, 2);
    add(0, 1, 1, mk(P_PRE,1,0),        0, 0,  1, C_PREA, 0,        0, 0,      16'h0000, I_NONE,  4, 3, 2);
    add(0, 1, 1, mk(P_MRS,0,0),        0, 0,  1, C_MRS,  0,        0, 0,      16'h0000, I_NONE,  4, 3, 2);
    add(1, 1, 0, mk(P_MRS,0,0),        0, 0,  0, C_DES,  0,        0, 0,      16'h0000, I_NONE,  4, 3, 2);

    for (int i = 0; i < vq.size(); i++) begin
      d1_cs_n = vq[i].cs_n; d1_act_n = vq[i].act_n; d1_cke = vq[i].cke;
      d1_a = vq[i].a; d1_bg = vq[i].bg; d1_ba = vq[i].ba;
      @(posedge clk); #1;
      check($sformatf("v%0d.valid", i), d1_valid, vq[i].e_valid);
      check($sformatf("v%0d.cmd", i),   d1_cmd,   vq[i].e_cmd);
      if (!vq[i].row_dc) check($sformatf("v%0d.row", i), d1_row, vq[i].e_row);
      check($sformatf("v%0d.col", i),   d1_col,   vq[i].e_col);
      check($sformatf("v%0d.bank", i),  d1_bank,  vq[i].e_valid ? {vq[i].bg, vq[i].ba} : 4'h0);
      check($sformatf("v%0d.open", i),  d1_open,  vq[i].e_open);
      check($sformatf("v%0d.ill", i),   d1_ill,   vq[i].e_code != I_NONE);
      check($sformatf("v%0d.code", i),  d1_code,  vq[i].e_code);
      check($sformatf("v%0d.act", i),   d1_act,   vq[i].e_act);
      check($sformatf("v%0d.rd", i),    d1_rd,    vq[i].e_rd);
      check($sformatf("v%0d.wr", i),    d1_wr,    vq[i].e_wr);
    end

    // Illegal pulse lasts one cycle
    d1_cs_n = 1'b0; d1_act_n = 1'b1; d1_a = mk(P_RFU,0,0);
    @(posedge clk); #1;
    check("pulse.ill1", d1_ill, 1);
    d1_a = mk(P_NOP,0,0);
    @(posedge clk); #1;
    check("pulse.ill0", d1_ill, 0);

    // Asynchronous reset mid-stream
    d1_cs_n = 1'b0; d1_act_n = 1'b0; d1_a = 17'h01ABC; d1_bg = 2'd1; d1_ba = 2'd1;
    @(posedge clk); #1;
    check("mid.open_pre", d1_open, 16'h0020);
    check("mid.act_pre",  d1_act,  5);
    d1_cs_n = 1'b1; d1_act_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("mid.open",  d1_open,  0);
    check("mid.act",   d1_act,   0);
    check("mid.rd",    d1_rd,    0);
    check("mid.cmd",   d1_cmd,   C_NOP);
    check("mid.valid", d1_valid, 0);
    #2 reset_n = 1'b1;

    // Two ranks
    drive2(2'b00, 1'b0, 17'h00055, 0, 0);
    check("r2.mcs.ill",   d2_ill,   1);
    check("r2.mcs.code",  d2_code,  I_MCS);
    check("r2.mcs.valid", d2_valid, 0);
    check("r2.mcs.open",  d2_open,  0);
    check("r2.mcs.act",   d2_act,   0);
    drive2(2'b01, 1'b0, 17'h00055, 0, 0);
    check("r2.act1.cmd",  d2_cmd,   C_ACT);
    check("r2.act1.rank", d2_rank,  1);
    check("r2.act1.row",  d2_row,   17'h55);
    check("r2.act1.open", d2_open,  32'h0001_0000);
    check("r2.act1.act",  d2_act,   1);
    drive2(2'b10, 1'b1, mk(P_PRE,1,0), 0, 0);
    check("r2.prea0.cmd",  d2_cmd,  C_PREA);
    check("r2.prea0.rank", d2_rank, 0);
    check("r2.prea0.open", d2_open, 32'h0001_0000);
    drive2(2'b01, 1'b1, mk(P_REF,0,0), 0, 0);
    check("r2.ref1.code", d2_code,  I_BOPEN);
    check("r2.ref1.cmd",  d2_cmd,   C_REF);
    check("r2.ref1.open", d2_open,  32'h0001_0000);
    drive2(2'b10, 1'b1, mk(P_REF,0,0), 0, 0);
    check("r2.ref0.ill",  d2_ill,   0);
    check("r2.ref0.cmd",  d2_cmd,   C_REF);
    drive2(2'b01, 1'b1, mk(P_PRE,1,0), 0, 0);
    check("r2.prea1.open", d2_open, 0);
    drive2(2'b01, 1'b1, mk(P_REF,0,0), 0, 0);
    check("r2.ref1b.ill",   d2_ill,   0);
    check("r2.ref1b.valid", d2_valid, 1);
    check("r2.ref1b.cmd",   d2_cmd,   C_REF);

    // Counter saturation: act_cnt starts at 1 here and stops at 4'hF
    for (int i = 0; i < 16; i++) begin
      drive2(2'b10, 1'b0, 17'(i), 0, 0);
      check($sformatf("sat%0d.act", i),  d2_act,  (i + 2 > 15) ? 4'hF : 4'(i + 2));
      check($sformatf("sat%0d.open", i), d2_open, 32'h0000_0001);
      drive2(2'b10, 1'b1, mk(P_PRE,0,0), 0, 0);
      check($sformatf("sat%0d.pre", i),  d2_open, 32'h0);
    end
    check("sat.final", d2_act, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
